frame_swap_controller: RTL and testbench
========================================

Name: frame_swap_controller

Overview:
Parametrised double/triple-buffer swap manager between the renderer and the VGA scan-out path.
- Owns which frame buffer the renderer writes and which the display reads.
- Gates per-buffer write enables and muxes scan-out pixel data.
- Commits finished frames only at vertical-sync boundaries, so the display never tears.
- In triple mode the renderer never stalls: the newest completed frame wins and stale pending frames are dropped.

Parameters:
NUM_BUFFERS, 2, number of frame buffers; legal values 2 (double) or 3 (triple), elaborate-time error otherwise.
DATA_WIDTH, 4, pixel data width per buffer.
CNT_WIDTH, 8, width of the statistics counters.

Ports:
clk  in  1  single system clock; all inputs are synchronous to it.
reset  in  1  synchronous, active-high reset.
vga_vs  in  1  vertical sync from the VGA controller; a frame boundary is its rising edge.
vga_blank  in  1  display enable; 1 = active video.
gpu_done  in  1  single-cycle pulse from the renderer: frame complete.
gpu_we  in  1  renderer pixel write strobe.
buf_rd_data  in  NUM_BUFFERS*DATA_WIDTH  packed read data; buffer i is slice i.
gpu_start  out  1  single-cycle pulse: begin rendering into write_idx.
buf_we  out  NUM_BUFFERS  one-hot-or-zero per-buffer write enable.
disp_data  out  DATA_WIDTH  pixel data for the DAC.
write_idx  out  $clog2(NUM_BUFFERS)  buffer currently owned by the renderer.
display_idx  out  $clog2(NUM_BUFFERS)  buffer currently scanned out.
drop_count  out  CNT_WIDTH  saturating count of completed frames discarded unshown.
repeat_count  out  CNT_WIDTH  saturating count of boundaries with no new frame.

Behaviour:
Reset (synchronous, dominates everything):
- state=IDLE, display_idx=0, write_idx=1, pending_valid=0, both counters 0, internal vs_q=0.
- gpu_start=0 and buf_we=0 throughout reset.

Frame boundary:
- vs_rise = vga_vs & ~vs_q, with vs_q registered every cycle.
- A vga_vs already high when reset releases does not produce an edge.

FSM states: IDLE, START, RENDER, WAIT_BUF.
- IDLE goes to START unconditionally.
- START: gpu_start=1 for exactly this cycle, then RENDER.
- RENDER: on gpu_done, the frame in write_idx is complete:
  - If NUM_BUFFERS=2: it becomes pending; go to WAIT_BUF.
  - If NUM_BUFFERS=3 and pending_valid=1: the old pending buffer is dropped (drop_count++); the completed buffer becomes pending; write_idx takes the dropped buffer; go to START.
  - If NUM_BUFFERS=3 and pending_valid=0: the completed buffer becomes pending; write_idx takes the index that is neither display_idx nor the new pending; go to START.
- WAIT_BUF (double mode only): holds until vs_rise, then swaps (see below) and goes to START.
- gpu_done outside RENDER is ignored.

On vs_rise:
- If pending_valid=1: display_idx takes pending_idx and pending_valid clears.
- If pending_valid=0: repeat_count++ and display_idx holds.
- In double mode the swap also sets write_idx to the old display_idx.

Simultaneous gpu_done and vs_rise in RENDER:
- The just-completed buffer is displayed immediately; display_idx takes the old write_idx.
- Any older pending frame is dropped (drop_count++) and pending_valid=0.
- write_idx takes the lowest index not equal to the new display_idx.
- Next state is START; repeat_count does not increment.

Outputs:
- buf_we[write_idx]=gpu_we only while state=RENDER; all bits 0 otherwise.
- disp_data = slice[display_idx] of buf_rd_data when vga_blank=1, else 0; purely combinational.
- Counters saturate at all-ones.
- Invariants checked by assertion:
  - write_idx != display_idx always.
  - When pending_valid=1, pending_idx differs from both write_idx and display_idx.

Latency:
- gpu_done to gpu_start is 1 cycle in triple mode.
- vs_rise to new display_idx is 1 cycle (registered).

Decomposition:
- Package frame_swap_pkg holds:
  - the state enum (IDLE, START, RENDER, WAIT_BUF);
  - the function free_index(display, pending, pending_valid), returning the lowest index not in use.
- One natural sub-module: rise_detect, a registered rising-edge pulse generator used for vga_vs.

Test Plan:
- Reset released with NUM_BUFFERS=2 -> display_idx=0, write_idx=1, gpu_start pulses exactly 1 cycle, 2 cycles after release; buf_we=0 in IDLE/START.
- Double mode: gpu_done, then vs_rise 50 cycles later -> WAIT_BUF holds with gpu_start=0; after the edge, display_idx=1, write_idx=0, gpu_start pulses once.
- Triple mode: two gpu_done pulses with no vs_rise between -> drop_count=1, no WAIT_BUF, write_idx never equals display_idx or pending; the next vs_rise shows the second frame.
- Four vs_rise edges with no gpu_done -> repeat_count=4 and display_idx unchanged; 300 edges -> repeat_count=255 (saturated).
- gpu_done and vs_rise in the same cycle (triple, pending_valid=1) -> display_idx=old write_idx, drop_count++, repeat_count unchanged, gpu_start next cycle.
- gpu_we=1 with vga_blank toggling -> buf_we only on write_idx during RENDER; disp_data=0 while vga_blank=0; reset asserted mid-RENDER returns to the reset values the next cycle.

Source files
------------

// File: rtl/frame_swap_pkg.sv
// Shared types and helpers for the frame swap controller.
//   state_t    : renderer handshake FSM states
//   free_index : lowest buffer index that is neither displayed nor pending
package frame_swap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    RENDER   = 2'd2,
    WAIT_BUF = 2'd3
  } state_t;

  localparam int unsigned MAX_BUFFERS = 3;

  function automatic int unsigned free_index(input int unsigned display,
                                             input int unsigned pending,
                                             input logic        pending_valid);
    int unsigned result;
    logic        found;
    result = 0;
    found  = 1'b0;
    for (int unsigned i = 0; i < MAX_BUFFERS; i++) begin
      if (!found && (i != display) && !(pending_valid && (i == pending))) begin
        result = i;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_swap_controller_rise_detect.sv
// Rising-edge detector for vertical sync.
//   clk, reset : system clock, synchronous active-high reset
//   sig        : level input (vga_vs)
//   rise       : high for the one cycle in which sig is high and was low
// The detector is disarmed for the first cycle after reset so that a level
// already high when reset releases is not mistaken for a fresh edge.
module rise_detect
  import frame_swap_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic vs_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vs_q    <= sig;
      armed_q <= 1'b1;
    end
  end

  assign rise = sig & ~vs_q & armed_q;

endmodule

// File: rtl/frame_swap_controller.sv
// Double/triple frame buffer swap manager between renderer and VGA scan-out.
//   clk, reset   : system clock, synchronous active-high reset
//   vga_vs       : vertical sync; rising edge is the frame boundary
//   vga_blank    : 1 = active video
//   gpu_done     : renderer frame-complete pulse
//   gpu_we       : renderer pixel write strobe
//   buf_rd_data  : packed read data, buffer i in slice i
//   gpu_start    : pulse telling the renderer to begin on write_idx
//   buf_we       : per-buffer write enable (one-hot or zero)
//   disp_data    : pixel to the DAC (0 outside active video)
//   write_idx    : buffer owned by the renderer
//   display_idx  : buffer being scanned out
//   drop_count   : completed frames discarded unshown (saturating)
//   repeat_count : frame boundaries with no new frame (saturating)
module frame_swap_controller
  import frame_swap_pkg::*;
#(
  parameter int NUM_BUFFERS = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              vga_vs,
  input  logic                              vga_blank,
  input  logic                              gpu_done,
  input  logic                              gpu_we,
  input  logic [NUM_BUFFERS*DATA_WIDTH-1:0] buf_rd_data,
  output logic                              gpu_start,
  output logic [NUM_BUFFERS-1:0]            buf_we,
  output logic [DATA_WIDTH-1:0]             disp_data,
  output logic [$clog2(NUM_BUFFERS)-1:0]    write_idx,
  output logic [$clog2(NUM_BUFFERS)-1:0]    display_idx,
  output logic [CNT_WIDTH-1:0]              drop_count,
  output logic [CNT_WIDTH-1:0]              repeat_count
);

  localparam int IDX_W  = $clog2(NUM_BUFFERS);
  localparam bit TRIPLE = (NUM_BUFFERS == 3);

  if ((NUM_BUFFERS != 2) && (NUM_BUFFERS != 3)) begin : g_bad_num_buffers
    $error("frame_swap_controller: NUM_BUFFERS must be 2 or 3");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     display_q, display_d;
  logic [IDX_W-1:0]     write_q, write_d;
  logic [IDX_W-1:0]     pend_q, pend_d;
  logic                 pv_q, pv_d;
  logic [CNT_WIDTH-1:0] drop_q, repeat_q;
  logic                 drop_inc, repeat_inc;
  logic                 vs_rise;

  rise_detect u_vs_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (vga_vs),
    .rise  (vs_rise)
  );

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      display_q <= '0;
      write_q   <= IDX_W'(1);
      pend_q    <= '0;
      pv_q      <= 1'b0;
      drop_q    <= '0;
      repeat_q  <= '0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      write_q   <= write_d;
      pend_q    <= pend_d;
      pv_q      <= pv_d;
      if (drop_inc)   drop_q   <= sat_inc(drop_q);
      if (repeat_inc) repeat_q <= sat_inc(repeat_q);
    end
  end

  // ---- next state / buffer ownership ----
  always_comb begin
    state_d    = state_q;
    display_d  = display_q;
    write_d    = write_q;
    pend_d     = pend_q;
    pv_d       = pv_q;
    drop_inc   = 1'b0;
    repeat_inc = 1'b0;

    case (state_q)
      IDLE:     state_d = START;
      START:    state_d = RENDER;
      RENDER:   if (gpu_done) state_d = TRIPLE ? START : WAIT_BUF;
      WAIT_BUF: if (vs_rise)  state_d = START;
      default:  state_d = IDLE;
    endcase

    if ((state_q == RENDER) && gpu_done && vs_rise) begin
      // Frame finished exactly on the boundary: show it now, anything older is stale.
      display_d = write_q;
      drop_inc  = pv_q;
      pv_d      = 1'b0;
      write_d   = IDX_W'(free_index(32'(write_q), 32'd0, 1'b0));
      state_d   = START;
    end else begin
      if ((state_q == RENDER) && gpu_done) begin
        pend_d = write_q;
        pv_d   = 1'b1;
        if (TRIPLE) begin
          if (pv_q) begin
            // Newest frame wins; the renderer recycles the dropped buffer.
            drop_inc = 1'b1;
            write_d  = pend_q;
          end else begin
            write_d = IDX_W'(free_index(32'(display_q), 32'(write_q), 1'b1));
          end
        end
      end
      if (vs_rise) begin
        if (pv_q) begin
          display_d = pend_q;
          pv_d      = 1'b0;
          if (!TRIPLE) write_d = display_q;
        end else begin
          repeat_inc = 1'b1;
        end
      end
    end
  end

  // ---- outputs ----
  always_comb begin
    buf_we    = '0;
    disp_data = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if ((state_q == RENDER) && (write_q == IDX_W'(i))) buf_we[i] = gpu_we;
      if (vga_blank && (display_q == IDX_W'(i)))
        disp_data = buf_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign gpu_start    = (state_q == START);
  assign write_idx    = write_q;
  assign display_idx  = display_q;
  assign drop_count   = drop_q;
  assign repeat_count = repeat_q;

  a_write_ne_display: assert property (@(posedge clk) disable iff (reset)
    write_q != display_q);

  // In double mode the pending frame sits in the renderer's own buffer while
  // it waits for vsync, so the pending-distinct check only applies to triple.
  if (TRIPLE) begin : g_pend_chk
    a_pending_distinct: assert property (@(posedge clk) disable iff (reset)
      pv_q |-> ((pend_q != write_q) && (pend_q != display_q)));
  end

endmodule

// File: tb/tb_frame_swap_controller.sv
module tb_frame_swap_controller;

  localparam int F_DISP_IDX = 0;
  localparam int F_WR       = 1;
  localparam int F_DROP     = 2;
  localparam int F_REP      = 3;
  localparam int F_WE       = 4;
  localparam int F_DISP     = 5;

  logic clk = 1'b0;
  logic reset;
  logic vga_blank, gpu_we;
  logic vs2, vs3, done2, done3;
  logic [7:0]  rd2;
  logic [11:0] rd3;

  logic       gs2, gs3;
  logic [1:0] we2;
  logic [2:0] we3;
  logic [3:0] dd2, dd3;
  logic       wi2, di2;
  logic [1:0] wi3, di3;
  logic [7:0] drop2, rep2, drop3, rep3;

  frame_swap_controller #(.NUM_BUFFERS(2), .DATA_WIDTH(4), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .vga_vs(vs2), .vga_blank(vga_blank),
    .gpu_done(done2), .gpu_we(gpu_we), .buf_rd_data(rd2),
    .gpu_start(gs2), .buf_we(we2), .disp_data(dd2),
    .write_idx(wi2), .display_idx(di2),
    .drop_count(drop2), .repeat_count(rep2)
  );

  frame_swap_controller #(.NUM_BUFFERS(3), .DATA_WIDTH(4), .CNT_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .vga_vs(vs3), .vga_blank(vga_blank),
    .gpu_done(done3), .gpu_we(gpu_we), .buf_rd_data(rd3),
    .gpu_start(gs3), .buf_we(we3), .disp_data(dd3),
    .write_idx(wi3), .display_idx(di3),
    .drop_count(drop3), .repeat_count(rep3)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int          dut;
    int          fld;
    int unsigned val;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned gs_exp2[$];
  int unsigned gs_exp3[$];
  int          nchk = 0;
  int          nerr = 0;

  function automatic int unsigned peek(input int d, input int f);
    int unsigned v;
    v = 0;
    if (d == 2) begin
      case (f)
        F_DISP_IDX: v = 32'(di2);
        F_WR:       v = 32'(wi2);
        F_DROP:     v = 32'(drop2);
        F_REP:      v = 32'(rep2);
        F_WE:       v = 32'(we2);
        default:    v = 32'(dd2);
      endcase
    end else begin
      case (f)
        F_DISP_IDX: v = 32'(di3);
        F_WR:       v = 32'(wi3);
        F_DROP:     v = 32'(drop3);
        F_REP:      v = 32'(rep3);
        F_WE:       v = 32'(we3);
        default:    v = 32'(dd3);
      endcase
    end
    return v;
  endfunction

  // Expected gpu_start pulses are matched in order against the pulses seen.
  function automatic void check_start(input int d, input logic gs);
    int unsigned front;
    int          sz;
    sz    = (d == 2) ? gs_exp2.size() : gs_exp3.size();
    front = (sz == 0) ? 0 : ((d == 2) ? gs_exp2[0] : gs_exp3[0]);
    if (sz != 0 && front < cyc) begin
      nchk++; nerr++;
      $display("FAIL gpu_start dut%0d: no pulse seen, required at cycle %0d (now %0d)", d, front, cyc);
      if (d == 2) void'(gs_exp2.pop_front()); else void'(gs_exp3.pop_front());
    end else if (gs) begin
      nchk++;
      if (sz == 0 || front != cyc) begin
        nerr++;
        $display("FAIL gpu_start dut%0d: pulse at cycle %0d, required next pulse at %0d (pending=%0d)",
                 d, cyc, front, sz);
      end else begin
        if (d == 2) void'(gs_exp2.pop_front()); else void'(gs_exp3.pop_front());
      end
    end
  endfunction

  int          mon_i;
  int unsigned mon_act;
  always @(negedge clk) begin
    mon_i = 0;
    while (mon_i < sb.size()) begin
      if (sb[mon_i].cyc <= cyc) begin
        mon_act = peek(sb[mon_i].dut, sb[mon_i].fld);
        nchk++;
        if (sb[mon_i].cyc < cyc) begin
          nerr++;
          $display("FAIL %s dut%0d: missed cycle %0d, got %0d, required %0d",
                   sb[mon_i].name, sb[mon_i].dut, sb[mon_i].cyc, mon_act, sb[mon_i].val);
        end else if (mon_act != sb[mon_i].val) begin
          nerr++;
          $display("FAIL %s dut%0d: got %0d, required %0d",
                   sb[mon_i].name, sb[mon_i].dut, mon_act, sb[mon_i].val);
        end
        sb.delete(mon_i);
      end else begin
        mon_i++;
      end
    end
    check_start(2, gs2);
    check_start(3, gs3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) step();
  endtask

  task automatic expect_at(input int d, input int f, input int unsigned v,
                           input int dly, input string nm);
    chk_t c;
    c.cyc  = cyc + dly;
    c.dut  = d;
    c.fld  = f;
    c.val  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic expect_start(input int d, input int dly);
    if (d == 2) gs_exp2.push_back(cyc + dly);
    else        gs_exp3.push_back(cyc + dly);
  endtask

  task automatic expect_reset_vals(input int d, input int dly);
    expect_at(d, F_DISP_IDX, 0, dly, "rst_display_idx");
    expect_at(d, F_WR,       1, dly, "rst_write_idx");
    expect_at(d, F_DROP,     0, dly, "rst_drop_count");
    expect_at(d, F_REP,      0, dly, "rst_repeat_count");
    expect_at(d, F_WE,       0, dly, "rst_buf_we");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required $finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; gpu_we = 1'b1; vga_blank = 1'b0;
    vs2 = 1'b0; vs3 = 1'b0; done2 = 1'b0; done3 = 1'b0;
    rd2 = 8'hA5;    // buf0=5 buf1=A
    rd3 = 12'h3C7;  // buf0=7 buf1=C buf2=3
    ticks(3);
    expect_reset_vals(2, 0);
    expect_reset_vals(3, 0);

    // Release: IDLE this cycle, START next, then RENDER.
    reset = 1'b0;
    expect_at(2, F_WE, 0, 0, "we_idle");
    expect_at(3, F_WE, 0, 0, "we_idle");
    expect_start(2, 1);
    expect_start(3, 1);
    expect_at(2, F_WE, 0, 1, "we_start");
    expect_at(3, F_WE, 0, 1, "we_start");
    expect_at(2, F_WE, 2, 2, "we_render");
    expect_at(3, F_WE, 2, 2, "we_render");
    ticks(2);

    // Scan-out mux and blanking.
    vga_blank = 1'b1;
    expect_at(2, F_DISP, 5, 0, "disp_active");
    expect_at(3, F_DISP, 7, 0, "disp_active");
    step();
    vga_blank = 1'b0;
    expect_at(2, F_DISP, 0, 0, "disp_blank");
    expect_at(3, F_DISP, 0, 0, "disp_blank");
    step();
    vga_blank = 1'b1;
    gpu_we = 1'b0;
    expect_at(2, F_WE, 0, 0, "we_strobe_low");
    step();
    gpu_we = 1'b1;

    // Double mode: finish a frame, wait ~50 cycles for vsync.
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    expect_at(2, F_WE, 0, 0, "we_wait_buf");
    expect_at(2, F_WR, 1, 0, "wait_write_idx");
    ticks(49);
    expect_at(2, F_DISP_IDX, 0, 0, "wait_hold_display");
    vs2 = 1'b1;
    expect_at(2, F_DISP_IDX, 1, 1, "swap_display_idx");
    expect_at(2, F_WR, 0, 1, "swap_write_idx");
    expect_at(2, F_DISP, 4'hA, 1, "swap_disp_data");
    expect_at(2, F_WE, 1, 2, "swap_we_render");
    expect_start(2, 1);
    ticks(3);
    vs2 = 1'b0;
    expect_at(2, F_REP, 0, 0, "swap_no_repeat");
    step();

    // Repeats with no new frame, then saturation.
    for (int i = 0; i < 4; i++) begin
      vs2 = 1'b1; step(); vs2 = 1'b0; step();
    end
    expect_at(2, F_REP, 4, 0, "repeat_4");
    expect_at(2, F_DISP_IDX, 1, 0, "repeat_display_hold");
    for (int i = 0; i < 296; i++) begin
      vs2 = 1'b1; step(); vs2 = 1'b0; step();
    end
    expect_at(2, F_REP, 255, 0, "repeat_saturate");
    expect_at(2, F_DROP, 0, 0, "double_no_drop");
    step();

    // Triple mode: display 0, write 1, nothing pending.
    done3 = 1'b1;
    expect_at(3, F_WR, 2, 1, "tri_first_write_idx");
    expect_at(3, F_DROP, 0, 1, "tri_first_drop");
    expect_start(3, 1);
    step();
    done3 = 1'b0;
    step();
    done3 = 1'b1;
    expect_at(3, F_WR, 1, 1, "tri_second_write_idx");
    expect_at(3, F_DROP, 1, 1, "tri_second_drop");
    expect_at(3, F_DISP_IDX, 0, 1, "tri_display_hold");
    expect_start(3, 1);
    step();
    // done held into START must be ignored
    expect_at(3, F_WR, 1, 1, "ignored_done_write_idx");
    expect_at(3, F_DROP, 1, 1, "ignored_done_drop");
    step();
    done3 = 1'b0;
    expect_at(3, F_WE, 2, 0, "tri_we_render");
    ticks(3);
    vs3 = 1'b1;
    expect_at(3, F_DISP_IDX, 2, 1, "tri_shows_second");
    expect_at(3, F_WR, 1, 1, "tri_write_after_vs");
    expect_at(3, F_REP, 0, 1, "tri_no_repeat");
    expect_at(3, F_DISP, 3, 1, "tri_disp_data");
    step();
    vs3 = 1'b0;
    step();

    // Build a pending frame, then done and vsync in the same cycle.
    done3 = 1'b1;
    expect_at(3, F_WR, 0, 1, "pre_sim_write_idx");
    expect_start(3, 1);
    step();
    done3 = 1'b0;
    step();
    done3 = 1'b1;
    vs3 = 1'b1;
    expect_at(3, F_DISP_IDX, 0, 1, "sim_display_idx");
    expect_at(3, F_DROP, 2, 1, "sim_drop_count");
    expect_at(3, F_REP, 0, 1, "sim_repeat_count");
    expect_at(3, F_WR, 1, 1, "sim_write_idx");
    expect_start(3, 1);
    step();
    done3 = 1'b0;
    vs3 = 1'b0;
    ticks(2);
    vs3 = 1'b1;
    expect_at(3, F_REP, 1, 1, "tri_repeat_after_sim");
    step();
    vs3 = 1'b0;
    ticks(2);

    // Reset mid-RENDER, with vga_vs high across the release.
    reset = 1'b1;
    vs3 = 1'b1;
    expect_reset_vals(2, 1);
    expect_reset_vals(3, 1);
    step();
    step();
    reset = 1'b0;
    expect_start(2, 1);
    expect_start(3, 1);
    ticks(3);
    expect_at(3, F_REP, 0, 0, "vs_high_at_release");
    expect_at(3, F_DISP_IDX, 0, 0, "vs_high_display_idx");
    ticks(3);

    foreach (gs_exp2[i]) begin
      nchk++; nerr++;
      $display("FAIL gpu_start dut2: no pulse seen, required at cycle %0d", gs_exp2[i]);
    end
    foreach (gs_exp3[i]) begin
      nchk++; nerr++;
      $display("FAIL gpu_start dut3: no pulse seen, required at cycle %0d", gs_exp3[i]);
    end
    foreach (sb[i]) begin
      nchk++; nerr++;
      $display("FAIL %s dut%0d: never sampled, required %0d", sb[i].name, sb[i].dut, sb[i].val);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
